ip_mem_tester: RTL and testbench

- Parametrised memory self-test engine for the PSRAM controller request ports (rd/wr/busy/address/wdata/rdata/rdata_en per channel).
- Writes a selectable pattern over an address range on every channel, reads it back and compares, then counts and captures failures.
- Emits an ASCII verdict through a byte-stream port that feeds ip_uart (send_data/send_req/send_busy).
- Replaces the hard-wired power-on test with a start/done controlled, multi-channel, multi-pattern block.

---
 rtl/ip_mem_tester_if.sv | 28 ++
 rtl/ip_mem_tester.sv | 233 +++++++++++++++++++++++
 tb/tb_ip_mem_tester.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_mem_tester_if.sv
// Request bus between ip_mem_tester and the PSRAM controller ports, plus the
// report byte stream towards ip_uart.
interface ip_mem_tester_if #(
   parameter int CH = 2,
   parameter int AW = 22,
   parameter int DW = 8
);
   logic [CH-1:0]    mem_rd;
   logic [CH-1:0]    mem_wr;
   logic [CH-1:0]    mem_busy;
   logic [AW-1:0]    mem_address;
   logic [DW-1:0]    mem_wdata;
   logic [CH*DW-1:0] mem_rdata;
   logic [CH-1:0]    mem_rdata_en;
   logic [7:0]       send_data;
   logic             send_req;
   logic             send_busy;

   modport master (
      output mem_rd, mem_wr, mem_address, mem_wdata, send_data, send_req,
      input  mem_busy, mem_rdata, mem_rdata_en, send_busy
   );

   modport slave (
      input  mem_rd, mem_wr, mem_address, mem_wdata, send_data, send_req,
      output mem_busy, mem_rdata, mem_rdata_en, send_busy
   );
endinterface

// File: rtl/ip_mem_tester.sv
// Multi-channel memory self-test: writes a pattern over 0..LAST_ADDR on every
// channel, reads it back, counts failures and reports OK/NG as ASCII bytes.
module ip_mem_tester #(
   parameter int CH        = 2,
   parameter int AW        = 22,
   parameter int DW        = 8,
   parameter int LAST_ADDR = (2 ** AW) - 1,
   parameter int TIMEOUT   = 1023
) (
   input  logic          clk,
   input  logic          n_reset,
   input  logic          start,
   input  logic [1:0]    mode,
   output logic          done,
   output logic          fail,
   output logic [15:0]   err_count,
   output logic [AW-1:0] fail_address,
   output logic [1:0]    fail_channel,
   ip_mem_tester_if.master bus
);
   localparam int HD = (AW + 3) / 4;
   localparam int HW = HD * 4;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, WRITE, READ_REQ, READ_WAIT, REPORT, DONE
   } state_t;

   state_t        state_r;
   logic [1:0]    mode_r;
   logic [AW-1:0] addr_r;
   logic [1:0]    ch_r;
   logic [TW-1:0] tmo_r;
   logic [4:0]    byte_idx_r;
   logic          done_r, fail_r;
   logic [15:0]   err_count_r;
   logic [AW-1:0] fail_address_r;
   logic [1:0]    fail_channel_r;
   logic [CH-1:0] mem_rd_r, mem_wr_r;
   logic [AW-1:0] mem_address_r;
   logic [DW-1:0] mem_wdata_r;
   logic [7:0]    send_data_r;
   logic          send_req_r;

   logic          req_prev_s, last_s, busy_sel_s, en_sel_s;
   logic [DW-1:0] rdata_sel_s, pattern_s;
   logic [CH-1:0] ch_onehot_s;
   logic [HW-1:0] fa_pad_s;
   logic [3:0]    hex_nib_s;
   logic [7:0]    report_byte_s;
   logic [4:0]    report_len_s;

   function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [AW-1:0] a);
      logic [DW-1:0] a_ext;
      a_ext = DW'(a);
      case (m)
         2'd0:    pattern = ~a_ext;
         2'd1:    pattern = a_ext;
         2'd2:    pattern = {{(DW-1){1'b0}}, 1'b1} << (a % DW);
         2'd3:    pattern = a[0] ? {(DW/2){2'b10}} : {(DW/2){2'b01}};
         default: pattern = '0;
      endcase
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      hex_ascii = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
   endfunction

   // Channel selection, pattern and request-spacing helpers
   always_comb begin
      busy_sel_s  = 1'b0;
      en_sel_s    = 1'b0;
      rdata_sel_s = '0;
      for (int c = 0; c < CH; c++) begin
         busy_sel_s  = busy_sel_s | (bus.mem_busy[c] & (ch_r == 2'(c)));
         en_sel_s    = en_sel_s | (bus.mem_rdata_en[c] & (ch_r == 2'(c)));
         rdata_sel_s = rdata_sel_s | (bus.mem_rdata[c*DW +: DW] & {DW{ch_r == 2'(c)}});
      end
      ch_onehot_s = CH'(1'b1) << ch_r;
      pattern_s   = pattern(mode_r, addr_r);
      req_prev_s  = (|mem_rd_r) | (|mem_wr_r) | send_req_r;
      last_s      = (addr_r == AW'(LAST_ADDR)) && (ch_r == 2'(CH - 1));
   end

   // Report byte for the current index: "OK\r\n" or "NG<hex address>\r\n"
   always_comb begin
      report_len_s = (err_count_r == 16'd0) ? 5'd4 : 5'(4 + HD);
      fa_pad_s     = HW'(fail_address_r);
      hex_nib_s    = 4'd0;
      for (int i = 0; i < HD; i++) begin
         hex_nib_s = hex_nib_s | (fa_pad_s[(HD-1-i)*4 +: 4] & {4{byte_idx_r == 5'(i + 2)}});
      end
      if (err_count_r == 16'd0) begin
         case (byte_idx_r)
            5'd0:    report_byte_s = 8'h4F;
            5'd1:    report_byte_s = 8'h4B;
            5'd2:    report_byte_s = 8'h0D;
            default: report_byte_s = 8'h0A;
         endcase
      end else if (byte_idx_r == 5'd0) begin
         report_byte_s = 8'h4E;
      end else if (byte_idx_r == 5'd1) begin
         report_byte_s = 8'h47;
      end else if (byte_idx_r < 5'(2 + HD)) begin
         report_byte_s = hex_ascii(hex_nib_s);
      end else if (byte_idx_r == 5'(2 + HD)) begin
         report_byte_s = 8'h0D;
      end else begin
         report_byte_s = 8'h0A;
      end
   end

   // Test sequencer with registered request and status outputs
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_r        <= IDLE;
         mode_r         <= 2'd0;
         addr_r         <= '0;
         ch_r           <= 2'd0;
         tmo_r          <= '0;
         byte_idx_r     <= 5'd0;
         done_r         <= 1'b0;
         fail_r         <= 1'b0;
         err_count_r    <= 16'd0;
         fail_address_r <= '0;
         fail_channel_r <= 2'd0;
         mem_rd_r       <= '0;
         mem_wr_r       <= '0;
         mem_address_r  <= '0;
         mem_wdata_r    <= '0;
         send_data_r    <= 8'd0;
         send_req_r     <= 1'b0;
      end else begin
         mem_rd_r   <= '0;
         mem_wr_r   <= '0;
         send_req_r <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  mode_r         <= mode;
                  err_count_r    <= 16'd0;
                  fail_r         <= 1'b0;
                  done_r         <= 1'b0;
                  fail_address_r <= '0;
                  fail_channel_r <= 2'd0;
                  addr_r         <= '0;
                  ch_r           <= 2'd0;
                  state_r        <= WRITE;
               end
            end
            WRITE: begin
               if (!req_prev_s && !busy_sel_s) begin
                  mem_wr_r      <= ch_onehot_s;
                  mem_address_r <= addr_r;
                  mem_wdata_r   <= pattern_s;
                  if (last_s) begin
                     addr_r  <= '0;
                     ch_r    <= 2'd0;
                     state_r <= READ_REQ;
                  end else if (ch_r == 2'(CH - 1)) begin
                     ch_r   <= 2'd0;
                     addr_r <= addr_r + AW'(1'b1);
                  end else begin
                     ch_r <= ch_r + 2'd1;
                  end
               end
            end
            READ_REQ: begin
               if (!req_prev_s && !busy_sel_s) begin
                  mem_rd_r      <= ch_onehot_s;
                  mem_address_r <= addr_r;
                  tmo_r         <= '0;
                  state_r       <= READ_WAIT;
               end
            end
            READ_WAIT: begin
               if (en_sel_s || (tmo_r == TW'(TIMEOUT))) begin
                  // A timeout and a data mismatch are both one failed compare
                  if (!en_sel_s || (rdata_sel_s != pattern_s)) begin
                     if (err_count_r != 16'hFFFF) begin
                        err_count_r <= err_count_r + 16'd1;
                     end
                     if (err_count_r == 16'd0) begin
                        fail_address_r <= addr_r;
                        fail_channel_r <= ch_r;
                     end
                  end
                  if (last_s) begin
                     addr_r     <= '0;
                     ch_r       <= 2'd0;
                     byte_idx_r <= 5'd0;
                     state_r    <= REPORT;
                  end else if (ch_r == 2'(CH - 1)) begin
                     ch_r    <= 2'd0;
                     addr_r  <= addr_r + AW'(1'b1);
                     state_r <= READ_REQ;
                  end else begin
                     ch_r    <= ch_r + 2'd1;
                     state_r <= READ_REQ;
                  end
               end else begin
                  tmo_r <= tmo_r + TW'(1'b1);
               end
            end
            REPORT: begin
               if (!req_prev_s && !bus.send_busy) begin
                  send_req_r  <= 1'b1;
                  send_data_r <= report_byte_s;
                  byte_idx_r  <= byte_idx_r + 5'd1;
                  if (byte_idx_r == report_len_s - 5'd1) begin
                     done_r  <= 1'b1;
                     fail_r  <= (err_count_r != 16'd0);
                     state_r <= DONE;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign done            = done_r;
   assign fail            = fail_r;
   assign err_count       = err_count_r;
   assign fail_address    = fail_address_r;
   assign fail_channel    = fail_channel_r;
   assign bus.mem_rd      = mem_rd_r;
   assign bus.mem_wr      = mem_wr_r;
   assign bus.mem_address = mem_address_r;
   assign bus.mem_wdata   = mem_wdata_r;
   assign bus.send_data   = send_data_r;
   assign bus.send_req    = send_req_r;
endmodule

// File: tb/tb_ip_mem_tester.sv
// Directed bench for ip_mem_tester (CH=2, AW=4, DW=8, TIMEOUT=15) with a
// zero-latency memory model, fault injection and a UART byte sink.
module tb_ip_mem_tester;
   localparam int CH = 2;
   localparam int AW = 4;
   localparam int DW = 8;

   typedef struct {
      int         ch;
      int         addr;
      logic [7:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic          done, fail;
   logic [15:0]   err_count;
   logic [AW-1:0] fail_address;
   logic [1:0]    fail_channel;

   ip_mem_tester_if #(.CH(CH), .AW(AW), .DW(DW)) bus ();

   ip_mem_tester #(.CH(CH), .AW(AW), .DW(DW), .TIMEOUT(15)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .start        (start),
      .mode         (mode),
      .done         (done),
      .fail         (fail),
      .err_count    (err_count),
      .fail_address (fail_address),
      .fail_channel (fail_channel),
      .bus          (bus.slave)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass = 0;
   wr_t        wq[$];
   logic [7:0] bq[$];
   int         rd_cnt = 0;
   int         proto_err = 0;
   logic [7:0] mem_arr [CH][16];
   logic       stuck_en = 1'b0;
   logic       drop_en = 1'b0;
   logic       prev_req = 1'b0;
   int         ubusy = 0;
   logic [CH-1:0] busy_drv = '0;

   assign bus.mem_busy = busy_drv;

   // Memory, UART sink and request-protocol monitor, all evaluated mid-cycle
   always @(negedge clk) begin
      logic [7:0] d;
      logic       req_now;
      bus.mem_rdata_en = '0;
      if (!n_reset) begin
         bus.mem_rdata = '0;
         bus.send_busy = 1'b0;
         ubusy         = 0;
         prev_req      = 1'b0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (bus.mem_wr[c]) begin
               mem_arr[c][bus.mem_address] = bus.mem_wdata;
               wq.push_back('{c, int'(bus.mem_address), bus.mem_wdata});
            end
            if (bus.mem_rd[c]) begin
               rd_cnt++;
               if (!(drop_en && c == 0 && bus.mem_address == 4'd2)) begin
                  d = mem_arr[c][bus.mem_address];
                  if (stuck_en && c == 1 && bus.mem_address == 4'd5) d[0] = 1'b0;
                  bus.mem_rdata[c*DW +: DW] = d;
                  bus.mem_rdata_en[c] = 1'b1;
               end
            end
         end
         req_now = (|bus.mem_rd) | (|bus.mem_wr) | bus.send_req;
         if ($countones({bus.mem_rd, bus.mem_wr}) > 1) proto_err++;
         if (req_now && prev_req) proto_err++;
         if (|((bus.mem_wr | bus.mem_rd) & busy_drv)) proto_err++;
         prev_req = req_now;
         if (bus.send_req) begin
            if (bus.send_busy) proto_err++;
            bq.push_back(bus.send_data);
            ubusy = 3;
         end else if (ubusy > 0) begin
            ubusy--;
         end
         bus.send_busy = (ubusy > 0);
      end
   end

   function automatic logic [7:0] exp_pat(input logic [1:0] m, input int a);
      logic [7:0] av;
      av = 8'(a);
      case (m)
         2'd0:    return 8'hFF ^ av;
         2'd1:    return av;
         2'd2:    return 8'h01 << (a % 8);
         default: return av[0] ? 8'hAA : 8'h55;
      endcase
   endfunction

   function automatic int seq_errors(input logic [1:0] m);
      int e = 0;
      if (wq.size() != 32) e++;
      foreach (wq[i]) begin
         if (wq[i].ch != i % 2 || wq[i].addr != i / 2 || wq[i].data !== exp_pat(m, i / 2)) e++;
      end
      return e;
   endfunction

   function automatic logic [7:0] wdata_at(input int idx);
      if (idx < wq.size()) return wq[idx].data;
      return 8'hxx;
   endfunction

   task automatic start_test(input logic [1:0] m);
      wq.delete();
      bq.delete();
      rd_cnt = 0;
      @(negedge clk);
      mode  = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (done !== 1'b1) $display("FAIL %s_done_timeout got done=%b want 1", name, done);
      else n_pass++;
   endtask

   task automatic check_bytes(input string name, input logic [7:0] exp[$]);
      n_checks++;
      if (bq != exp) $display("FAIL %s_bytes got %p want %p", name, bq, exp);
      else n_pass++;
   endtask

   task automatic check_pass(input string name);
      n_checks++;
      if ({fail, err_count} !== 17'd0) $display("FAIL %s_status got fail=%b err=%0d want 0/0", name, fail, err_count);
      else n_pass++;
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({done, fail, err_count, fail_address, fail_channel} !== 24'd0)
         $display("FAIL reset_status got %h want 0", {done, fail, err_count, fail_address, fail_channel});
      else n_pass++;
      n_checks++;
      if ({bus.mem_rd, bus.mem_wr, bus.send_req, bus.mem_address, bus.mem_wdata, bus.send_data} !== 25'd0)
         $display("FAIL reset_bus got %h want 0",
                  {bus.mem_rd, bus.mem_wr, bus.send_req, bus.mem_address, bus.mem_wdata, bus.send_data});
      else n_pass++;
      n_reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mode0_pass();
      start_test(2'd0);
      wait_done("mode0");
      n_checks++;
      if (seq_errors(2'd0) != 0) $display("FAIL mode0_write_seq got %0d bad writes want 0", seq_errors(2'd0));
      else n_pass++;
      n_checks++;
      if (wdata_at(6) !== 8'hFC) $display("FAIL mode0_addr3_wdata got %h want fc", wdata_at(6));
      else n_pass++;
      n_checks++;
      if (rd_cnt != 32) $display("FAIL mode0_reads got %0d want 32", rd_cnt);
      else n_pass++;
      check_bytes("mode0", '{8'h4F, 8'h4B, 8'h0D, 8'h0A});
      check_pass("mode0");
   endtask

   task automatic test_stuck_bit();
      stuck_en = 1'b1;
      start_test(2'd1);
      wait_done("stuck");
      stuck_en = 1'b0;
      n_checks++;
      if ({fail, err_count, fail_address, fail_channel} !== {1'b1, 16'd1, 4'd5, 2'd1})
         $display("FAIL stuck_status got fail=%b err=%0d addr=%0d ch=%0d want 1/1/5/1",
                  fail, err_count, fail_address, fail_channel);
      else n_pass++;
      check_bytes("stuck", '{8'h4E, 8'h47, 8'h35, 8'h0D, 8'h0A});
   endtask

   task automatic test_busy();
      int cyc = 0;
      proto_err = 0;
      start_test(2'd1);
      while (wq.size() < 7 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      #1 busy_drv = 2'b11;
      repeat (10) @(negedge clk);
      #1 busy_drv = 2'b00;
      n_checks++;
      if (wq.size() < 7 || wq.size() > 8) $display("FAIL busy_stall got %0d writes want 7..8", wq.size());
      else n_pass++;
      wait_done("busy");
      n_checks++;
      if (proto_err != 0) $display("FAIL busy_protocol got %0d violations want 0", proto_err);
      else n_pass++;
      n_checks++;
      if (seq_errors(2'd1) != 0) $display("FAIL busy_write_seq got %0d bad writes want 0", seq_errors(2'd1));
      else n_pass++;
      check_pass("busy");
   endtask

   task automatic test_timeout();
      drop_en = 1'b1;
      start_test(2'd0);
      wait_done("timeout");
      drop_en = 1'b0;
      n_checks++;
      if ({err_count, fail_address, fail_channel, fail} !== {16'd1, 4'd2, 2'd0, 1'b1})
         $display("FAIL timeout_status got err=%0d addr=%0d ch=%0d fail=%b want 1/2/0/1",
                  err_count, fail_address, fail_channel, fail);
      else n_pass++;
      n_checks++;
      if (rd_cnt != 32) $display("FAIL timeout_reads got %0d want 32", rd_cnt);
      else n_pass++;
      check_bytes("timeout", '{8'h4E, 8'h47, 8'h32, 8'h0D, 8'h0A});
   endtask

   task automatic test_patterns();
      start_test(2'd2);
      wait_done("mode2");
      n_checks++;
      if (wdata_at(18) !== 8'h02) $display("FAIL mode2_addr9 got %h want 02", wdata_at(18));
      else n_pass++;
      n_checks++;
      if (seq_errors(2'd2) != 0) $display("FAIL mode2_write_seq got %0d bad writes want 0", seq_errors(2'd2));
      else n_pass++;
      check_pass("mode2");
      start_test(2'd3);
      wait_done("mode3");
      n_checks++;
      if ({wdata_at(8), wdata_at(11)} !== 16'h55AA)
         $display("FAIL mode3_alt got %h want 55aa", {wdata_at(8), wdata_at(11)});
      else n_pass++;
      n_checks++;
      if (seq_errors(2'd3) != 0) $display("FAIL mode3_write_seq got %0d bad writes want 0", seq_errors(2'd3));
      else n_pass++;
   endtask

   task automatic test_start_ignored();
      int cyc = 0;
      start_test(2'd0);
      while (rd_cnt < 3 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      while (bus.mem_rd == 2'b00 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      mode  = 2'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("start_ignored");
      n_checks++;
      if (wq.size() != 32 || rd_cnt != 32)
         $display("FAIL start_ignored_counts got %0d/%0d want 32/32", wq.size(), rd_cnt);
      else n_pass++;
      check_pass("start_ignored");
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      start_test(2'd1);
      while (wq.size() < 10 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      n_reset = 1'b0;
      #1;
      n_checks++;
      if ({done, err_count, bus.mem_wr, bus.mem_rd, bus.mem_address, bus.mem_wdata, bus.send_req} !== 34'd0)
         $display("FAIL reset_mid_outputs got %h want 0",
                  {done, err_count, bus.mem_wr, bus.mem_rd, bus.mem_address, bus.mem_wdata, bus.send_req});
      else n_pass++;
      @(negedge clk);
      n_reset = 1'b1;
      start_test(2'd0);
      wait_done("reset_mid");
      n_checks++;
      if (seq_errors(2'd0) != 0) $display("FAIL reset_mid_write_seq got %0d bad writes want 0", seq_errors(2'd0));
      else n_pass++;
      check_bytes("reset_mid", '{8'h4F, 8'h4B, 8'h0D, 8'h0A});
   endtask

   initial begin
      test_reset();
      test_mode0_pass();
      test_stuck_bit();
      test_busy();
      test_timeout();
      test_patterns();
      test_start_ignored();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
